i2c_send: RTL and testbench
===========================

# i2c_send

Write-only I2C master byte transmitter; the driving counterpart to the passive bus listener. Generates START, shifts out bytes MSB-first with SCL timing derived from `sysclk`, samples the slave ACK/NAK on the 9th clock, and issues STOP after the last byte or on NAK. Drives the bus through open-drain enables only, so the listener and the glitch logic can share the same wires.

## Interface
- `QUARTER`, 30: `sysclk` cycles per quarter SCL period; legal minimum 2.
- `sysclk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  byte to send; sampled on accept.
- `tx_valid`  in  1  byte offered.
- `tx_last`  in  1  offered byte is the final byte; sampled with `tx_data`.
- `tx_ready`  out  1  accept window; accept = `tx_valid && tx_ready`.
- `sda_oe`  out  1  1 = pull SDA low, 0 = release.
- `scl_oe`  out  1  1 = pull SCL low, 0 = release.
- `sda_in`  in  1  bus SDA level, pre-filtered.
- `scl_in`  in  1  bus SCL level; used only with `I2C_SEND_STRETCH_EN`.
- `busy`  out  1  high whenever state is not IDLE.
- `byte_done`  out  1  one-cycle pulse after each ACK slot.
- `nak`  out  1  ACK-slot SDA sample; valid while `byte_done` is high, holds until the next ACK slot.
- `stop_done`  out  1  one-cycle pulse when STOP and bus-free time complete.

## Operation
- Quarter counter: counts 0..QUARTER-1; a quarter tick fires at QUARTER-1, then the counter wraps to 0. Every state except IDLE and LOAD lasts exactly 2 ticks. The counter clears on every state change.
- IDLE: both enables 0, `tx_ready`=1. On accept, latch `tx_data` into the shift register and `tx_last` into the last flag, set bit index 7, go to START.
- START: `sda_oe`=1, `scl_oe`=0. Then BIT_LOW.
- BIT_LOW: `scl_oe`=1, `sda_oe`=~shift[7], set on state entry. Then BIT_HIGH.
- BIT_HIGH: `scl_oe`=0, SDA held. On exit, shift left. If bit index is 0, go to ACK_LOW; otherwise decrement the index and go to BIT_LOW.
- ACK_LOW: `scl_oe`=1, `sda_oe`=0.
- ACK_HIGH: `scl_oe`=0, `sda_oe`=0. Register `nak` from `sda_in` at the first tick. On exit, pulse `byte_done`. If `nak` or the last flag is set, go to STOP_LOW; otherwise go to LOAD.
- LOAD: `scl_oe`=1 (SCL held low), `sda_oe`=0, `tx_ready`=1, waits indefinitely. On accept, latch data and last flag, set index 7, go to BIT_LOW.
- STOP_LOW: `scl_oe`=1, `sda_oe`=1.
- STOP_HIGH: `scl_oe`=0, `sda_oe`=1.
- STOP_FREE: both enables 0. On exit, pulse `stop_done` and go to IDLE.
- `tx_valid` outside IDLE/LOAD is ignored and has no side effects.
- NAK on a non-last byte still goes to STOP; the pending byte is not consumed.
- `tx_ready` and `busy` are combinational state decodes. All other outputs are registered.

## Timing
- Reset values: `sda_oe`=0, `scl_oe`=0, `byte_done`=0, `nak`=0, `stop_done`=0, `busy`=0, `tx_ready`=1, state IDLE, counters 0.
- Reset mid-transfer releases both lines immediately (asynchronous). No STOP is generated.
- Accept → `sda_oe`=1 on the next `sysclk` edge.
- Per byte: 9 SCL periods = 36 quarters. START = 2 quarters. STOP sequence = 6 quarters.
- Single-byte transaction: accept → `stop_done` pulse = 44×QUARTER cycles.
- `byte_done` asserts on the first cycle of the next state. `stop_done` asserts on the first IDLE cycle.
- SDA changes only while SCL is low, except the START and STOP edges.

## Configuration
- `I2C_SEND_STRETCH_EN` defined: in BIT_HIGH, ACK_HIGH and STOP_HIGH, the quarter counter holds at 0 while `scl_in`=0, so slave clock stretching extends the high phase.
- `I2C_SEND_STRETCH_EN` undefined: `scl_in` is unused and timing is fixed.

## Test plan
All scenarios use QUARTER=4.
- Single byte, ACK: 0xA5 with `tx_last`=1; bench holds SDA low in the ACK slot. Expect 9 SCL low pulses and SDA bits 1,0,1,0,0,1,0,1 at the SCL rising edges. Expect `byte_done` with `nak`=0, then `stop_done` 176 cycles after accept.
- NAK abort: 0x3C with `tx_last`=0; bench leaves SDA released. Expect `nak`=1 with `byte_done`, then STOP and IDLE; a second offered byte is not accepted before IDLE.
- Two-byte burst with host gap: 0x12 (`tx_last`=0), then 0x34 (`tx_last`=1) offered 50 cycles after entering LOAD. Expect SCL held low for all 50 cycles, no STOP between bytes, and 2 `byte_done` pulses.
- Reset mid-byte: assert `rst_n`=0 during bit 4. Expect `sda_oe`=0 and `scl_oe`=0 in the same cycle, `tx_ready`=1 after release, and a clean transfer afterwards.
- Stretch, macro defined: hold `scl_in` low for 20 cycles at the start of bit 6 high. Expect that bit's high phase lengthened by 20 cycles and total latency 196 cycles. Macro undefined: latency stays 176 cycles.
- Ignored valid: pulse `tx_valid` during BIT_HIGH. Expect no change to shift register, state or outputs.

Source files
------------

// File: rtl/i2c_send.sv
// Write-only I2C master byte transmitter driving SDA/SCL through open-drain enables.
// Define I2C_SEND_STRETCH_EN to let a slave stretch SCL during the high phases.
module i2c_send #(
  parameter int QUARTER = 30
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       sda_oe,
  output logic       scl_oe,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       busy,
  output logic       byte_done,
  output logic       nak,
  output logic       stop_done
);

  localparam int CW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam logic [CW-1:0] QMAX = CW'(QUARTER - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_BIT_LOW, ST_BIT_HIGH, ST_ACK_LOW,
    ST_ACK_HIGH, ST_LOAD, ST_STOP_LOW, ST_STOP_HIGH, ST_STOP_FREE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] qcnt_q, qcnt_d;
  logic          phase_q, phase_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    idx_q, idx_d;
  logic          last_q, last_d;
  logic          nak_q, nak_d;
  logic          sda_oe_q, sda_oe_d;
  logic          scl_oe_q, scl_oe_d;
  logic          byte_done_q, byte_done_d;
  logic          stop_done_q, stop_done_d;

  logic accept, tick, state_exit, timed, stretch_hold;

  assign tx_ready   = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign busy       = (state_q != ST_IDLE);
  assign accept     = tx_valid && tx_ready;
  assign timed      = (state_q != ST_IDLE) && (state_q != ST_LOAD);
  assign tick       = timed && (qcnt_q == QMAX);
  assign state_exit = tick && phase_q;

`ifdef I2C_SEND_STRETCH_EN
  // A slave holding SCL low keeps the high-phase counter parked at zero.
  assign stretch_hold = !scl_in && ((state_q == ST_BIT_HIGH) ||
                                    (state_q == ST_ACK_HIGH) ||
                                    (state_q == ST_STOP_HIGH));
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign stretch_hold  = 1'b0;
`endif

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      qcnt_q      <= '0;
      phase_q     <= 1'b0;
      shift_q     <= '0;
      idx_q       <= '0;
      last_q      <= 1'b0;
      nak_q       <= 1'b0;
      sda_oe_q    <= 1'b0;
      scl_oe_q    <= 1'b0;
      byte_done_q <= 1'b0;
      stop_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      qcnt_q      <= qcnt_d;
      phase_q     <= phase_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      nak_q       <= nak_d;
      sda_oe_q    <= sda_oe_d;
      scl_oe_q    <= scl_oe_d;
      byte_done_q <= byte_done_d;
      stop_done_q <= stop_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    last_d  = last_q;
    nak_d   = nak_q;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (accept) begin
          shift_d = tx_data;
          last_d  = tx_last;
          idx_d   = 3'd7;
          state_d = (state_q == ST_IDLE) ? ST_START : ST_BIT_LOW;
        end
      end
      ST_START:    if (state_exit) state_d = ST_BIT_LOW;
      ST_BIT_LOW:  if (state_exit) state_d = ST_BIT_HIGH;
      ST_BIT_HIGH: begin
        if (state_exit) begin
          shift_d = {shift_q[6:0], 1'b0};
          if (idx_q == 3'd0) begin
            state_d = ST_ACK_LOW;
          end else begin
            idx_d   = idx_q - 3'd1;
            state_d = ST_BIT_LOW;
          end
        end
      end
      ST_ACK_LOW:  if (state_exit) state_d = ST_ACK_HIGH;
      ST_ACK_HIGH: begin
        if (tick && !phase_q) nak_d = sda_in;
        if (state_exit) state_d = (nak_q || last_q) ? ST_STOP_LOW : ST_LOAD;
      end
      ST_STOP_LOW:  if (state_exit) state_d = ST_STOP_HIGH;
      ST_STOP_HIGH: if (state_exit) state_d = ST_STOP_FREE;
      ST_STOP_FREE: if (state_exit) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    qcnt_d  = qcnt_q;
    phase_d = phase_q;
    if (state_d != state_q || !timed || stretch_hold) begin
      qcnt_d = '0;
      if (state_d != state_q || !timed) phase_d = 1'b0;
    end else if (tick) begin
      qcnt_d  = '0;
      phase_d = 1'b1;
    end else begin
      qcnt_d = qcnt_q + CW'(1);
    end
  end

  // Outputs are registered from the next state so they change with the state.
  always_comb begin
    sda_oe_d    = 1'b0;
    scl_oe_d    = 1'b0;
    byte_done_d = (state_q == ST_ACK_HIGH) && (state_d != ST_ACK_HIGH);
    stop_done_d = (state_q == ST_STOP_FREE) && (state_d == ST_IDLE);
    case (state_d)
      ST_START:     sda_oe_d = 1'b1;
      ST_BIT_LOW: begin
        scl_oe_d = 1'b1;
        sda_oe_d = ~shift_d[7];
      end
      ST_BIT_HIGH:  sda_oe_d = sda_oe_q;
      ST_ACK_LOW:   scl_oe_d = 1'b1;
      ST_LOAD:      scl_oe_d = 1'b1;
      ST_STOP_LOW: begin
        scl_oe_d = 1'b1;
        sda_oe_d = 1'b1;
      end
      ST_STOP_HIGH: sda_oe_d = 1'b1;
      default: begin
        sda_oe_d = 1'b0;
        scl_oe_d = 1'b0;
      end
    endcase
  end

  assign sda_oe    = sda_oe_q;
  assign scl_oe    = scl_oe_q;
  assign byte_done = byte_done_q;
  assign nak       = nak_q;
  assign stop_done = stop_done_q;

endmodule

// File: tb/tb_i2c_send.sv
// Scoreboard bench for i2c_send with QUARTER=4; expectations queued by stimulus, checked by monitor.
module tb_i2c_send;
  logic       sysclk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid, tx_last, tx_ready;
  logic       sda_oe, scl_oe, sda_in, scl_in;
  logic       busy, byte_done, nak, stop_done;
  logic       ack_en, stretch;

  i2c_send #(.QUARTER(4)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_last(tx_last), .tx_ready(tx_ready), .sda_oe(sda_oe), .scl_oe(scl_oe),
    .sda_in(sda_in), .scl_in(scl_in), .busy(busy), .byte_done(byte_done),
    .nak(nak), .stop_done(stop_done)
  );

  always #5 sysclk = ~sysclk;

  // Open-drain bus: slave ACK pulls SDA low, slave stretch pulls SCL low.
  assign sda_in = ~(sda_oe | ack_en);
  assign scl_in = ~(scl_oe | stretch);

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    int         kind;   // 0 = byte_done, 1 = stop_done
    logic [7:0] data;
    logic       nak;
    int         lat;    // -1 = latency not checked
  } exp_t;
  exp_t sb_q[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int kind, input logic [7:0] data, input logic n, input int lat);
    exp_t e;
    e.kind = kind; e.data = data; e.nak = n; e.lat = lat;
    sb_q.push_back(e);
  endtask

  // Monitor: reconstructs bytes from SDA at SCL release and pops on each output pulse.
  initial begin
    logic [8:0] acc;
    int         nlow;
    int         start_cyc;
    logic       prev_scl;
    exp_t       e;
    acc = '0; nlow = 0; start_cyc = 0; prev_scl = 1'b0;
    forever begin
      @(negedge sysclk);
      if (!rst_n) begin
        acc = '0; nlow = 0; prev_scl = 1'b0;
      end else begin
        if (tx_valid && tx_ready && !busy) begin
          start_cyc = cyc + 1;
          acc = '0; nlow = 0;
        end
        if (byte_done) begin
          if (sb_q.size() == 0) begin
            check("unexpected_byte_done", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("event_kind_byte", 0, e.kind);
            check("byte_data", int'(acc[8:1]), int'(e.data));
            check("byte_nak", int'(nak), int'(e.nak));
            check("scl_low_pulses", nlow, 9);
          end
          acc = '0; nlow = 0;
        end
        if (stop_done) begin
          if (sb_q.size() == 0) begin
            check("unexpected_stop_done", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("event_kind_stop", 1, e.kind);
            if (e.lat >= 0) check("accept_to_stop_latency", cyc - start_cyc, e.lat);
          end
        end
        if (!prev_scl && scl_oe) nlow++;
        if (prev_scl && !scl_oe) acc = {acc[7:0], ~sda_oe};
        prev_scl = scl_oe;
      end
    end
  end

  // All stimulus tasks are entered and left 1 time unit after a rising edge.
  task automatic send(input logic [7:0] d, input logic last, input bit from_idle);
    int n;
    tx_data = d; tx_last = last; tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 1000) begin
      @(posedge sysclk); #1; n++;
    end
    check("accept_wait", int'(n < 1000), 1);
    @(posedge sysclk); #1;
    tx_valid = 1'b0;
    if (from_idle) check("start_sda_oe", int'(sda_oe), 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 2000) begin
      @(posedge sysclk); #1; n++;
    end
    check("drain_pending", sb_q.size(), 0);
    check("drain_busy", int'(busy), 0);
  endtask

  task automatic wait_scl_fall(input int count);
    int   falls, n;
    logic prev;
    falls = 0; n = 0; prev = scl_oe;
    while (falls < count && n < 1000) begin
      @(posedge sysclk); #1; n++;
      if (prev && !scl_oe) falls++;
      prev = scl_oe;
    end
    check("scl_fall_wait", int'(n < 1000), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int viol, n;
    rst_n = 1'b0; tx_data = '0; tx_valid = 1'b0; tx_last = 1'b0;
    ack_en = 1'b1; stretch = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    check("rst_sda_oe", int'(sda_oe), 0);
    check("rst_scl_oe", int'(scl_oe), 0);
    check("rst_byte_done", int'(byte_done), 0);
    check("rst_nak", int'(nak), 0);
    check("rst_stop_done", int'(stop_done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_tx_ready", int'(tx_ready), 1);
    rst_n = 1'b1;
    @(posedge sysclk); #1;

    // Single byte with ACK.
    push_exp(0, 8'hA5, 1'b0, -1);
    push_exp(1, 8'h00, 1'b0, 176);
    send(8'hA5, 1'b1, 1'b1);
    drain();

    // NAK abort with a second byte offered throughout.
    ack_en = 1'b0;
    push_exp(0, 8'h3C, 1'b1, -1);
    push_exp(1, 8'h00, 1'b0, 176);
    send(8'h3C, 1'b0, 1'b1);
    tx_data = 8'h99; tx_last = 1'b1; tx_valid = 1'b1;
    viol = 0; n = 0;
    while (busy && n < 1000) begin
      if (tx_ready) viol++;
      @(posedge sysclk); #1; n++;
    end
    tx_valid = 1'b0;
    check("nak_no_early_accept", viol, 0);
    check("nak_reaches_idle", int'(busy), 0);
    drain();
    ack_en = 1'b1;

    // Two-byte burst with a 50-cycle host gap in LOAD.
    push_exp(0, 8'h12, 1'b0, -1);
    push_exp(0, 8'h34, 1'b0, -1);
    push_exp(1, 8'h00, 1'b0, -1);
    send(8'h12, 1'b0, 1'b1);
    n = 0;
    while (!byte_done && n < 1000) begin
      @(posedge sysclk); #1; n++;
    end
    check("burst_first_byte_wait", int'(n < 1000), 1);
    check("load_tx_ready", int'(tx_ready), 1);
    viol = 0;
    repeat (50) begin
      @(posedge sysclk); #1;
      if (!scl_oe) viol++;
    end
    check("load_scl_held_low", viol, 0);
    check("load_still_busy", int'(busy), 1);
    send(8'h34, 1'b1, 1'b0);
    drain();

    // Reset in the low phase of bit index 4 (0xC3 drives SDA low there).
    send(8'hC3, 1'b1, 1'b1);
    repeat (60) begin
      @(posedge sysclk); #1;
    end
    check("pre_reset_scl_oe", int'(scl_oe), 1);
    check("pre_reset_sda_oe", int'(sda_oe), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_sda_oe", int'(sda_oe), 0);
    check("async_rst_scl_oe", int'(scl_oe), 0);
    sb_q.delete();
    @(posedge sysclk); #1;
    rst_n = 1'b1;
    check("post_reset_tx_ready", int'(tx_ready), 1);
    push_exp(0, 8'h5A, 1'b0, -1);
    push_exp(1, 8'h00, 1'b0, 176);
    send(8'h5A, 1'b1, 1'b1);
    drain();

    // Slave stretch of 20 cycles at the start of bit index 6 high phase.
    push_exp(0, 8'hA5, 1'b0, -1);
`ifdef I2C_SEND_STRETCH_EN
    push_exp(1, 8'h00, 1'b0, 196);
`else
    push_exp(1, 8'h00, 1'b0, 176);
`endif
    send(8'hA5, 1'b1, 1'b1);
    wait_scl_fall(2);
    stretch = 1'b1;
    repeat (20) @(posedge sysclk);
    #1;
    stretch = 1'b0;
    drain();

    // tx_valid pulse during BIT_HIGH must be ignored.
    push_exp(0, 8'h81, 1'b0, -1);
    push_exp(1, 8'h00, 1'b0, 176);
    send(8'h81, 1'b1, 1'b1);
    wait_scl_fall(1);
    tx_data = 8'hFF; tx_last = 1'b0; tx_valid = 1'b1;
    check("ignored_tx_ready", int'(tx_ready), 0);
    @(posedge sysclk); #1;
    tx_valid = 1'b0;
    check("ignored_busy", int'(busy), 1);
    check("ignored_scl_released", int'(scl_oe), 0);
    check("ignored_sda_bit7", int'(sda_oe), 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
